// File: rtl/demux8_pkg.sv
// Shared types and constants for the registered 1-to-8 demultiplexer slice.
// Optional parity outputs are enabled by defining DEMUX8_PARITY_EN.
package demux8_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int         NUM_SLOTS = 8;
  localparam logic [7:0] FULL_MASK = 8'hFF;

  function automatic logic [7:0] onehot8(input logic [2:0] idx);
    return 8'd1 << idx;
  endfunction

endpackage

// File: rtl/demux8_4bits_seq_slot_reg.sv
// One held output slot: WIDTH-bit register with load enable and synchronous reset.
// With DEMUX8_PARITY_EN the even-parity bit of the slot is registered alongside it.
module slot_reg #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
`ifdef DEMUX8_PARITY_EN
  ,
  output logic             par
`endif
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of process ordering in simulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RESET_VAL;
    end else if (load) begin
      q <= d;
    end
  end

`ifdef DEMUX8_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      par <= ^RESET_VAL;
    end else if (load) begin
      par <= ^d;
    end
  end
`endif

endmodule

// File: rtl/demux8_4bits_seq.sv
// Registered 1-to-8 demultiplexer with auto/addressed slot selection and frame tracking.
// Define DEMUX8_PARITY_EN to add the per-slot parity output port par.
module demux8_4bits_seq
  import demux8_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] D,
  input  logic             valid,
  input  logic             auto_mode,
  input  logic [2:0]       sel,
  output logic [WIDTH-1:0] Y0,
  output logic [WIDTH-1:0] Y1,
  output logic [WIDTH-1:0] Y2,
  output logic [WIDTH-1:0] Y3,
  output logic [WIDTH-1:0] Y4,
  output logic [WIDTH-1:0] Y5,
  output logic [WIDTH-1:0] Y6,
  output logic [WIDTH-1:0] Y7,
  output logic [7:0]       filled,
  output logic [2:0]       ptr,
  output logic             frame_done
`ifdef DEMUX8_PARITY_EN
  ,
  output logic [7:0]       par
`endif
);

  state_t           state, state_nxt;
  logic [7:0]       filled_nxt;
  logic [2:0]       ptr_nxt;
  logic             frame_done_nxt;
  logic [2:0]       target;
  logic [7:0]       target_mask;
  logic [WIDTH-1:0] y_q [NUM_SLOTS];

  assign target      = auto_mode ? ptr : sel;
  assign target_mask = onehot8(target);

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_nxt      = state;
    filled_nxt     = filled;
    ptr_nxt        = ptr;
    frame_done_nxt = 1'b0;
    if (valid) begin
      if (auto_mode) begin
        ptr_nxt = ptr + 3'd1;
      end
      // A write in the DONE cycle opens a fresh frame with only its own flag.
      filled_nxt = (state == DONE) ? target_mask : (filled | target_mask);
      if (filled_nxt == FULL_MASK) begin
        state_nxt      = DONE;
        frame_done_nxt = 1'b1;
      end else begin
        state_nxt = FILL;
      end
    end else if (state == DONE) begin
      state_nxt  = IDLE;
      filled_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      filled     <= '0;
      ptr        <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      filled     <= filled_nxt;
      ptr        <= ptr_nxt;
      frame_done <= frame_done_nxt;
    end
  end

  for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_slot
    slot_reg #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_slot (
      .clk  (clk),
      .rst  (rst),
      .load (valid && (target == 3'(k))),
      .d    (D),
      .q    (y_q[k])
`ifdef DEMUX8_PARITY_EN
      ,
      .par  (par[k])
`endif
    );
  end

  assign Y0 = y_q[0];
  assign Y1 = y_q[1];
  assign Y2 = y_q[2];
  assign Y3 = y_q[3];
  assign Y4 = y_q[4];
  assign Y5 = y_q[5];
  assign Y6 = y_q[6];
  assign Y7 = y_q[7];

endmodule

// File: tb/tb_demux8_4bits_seq.sv
// Self-checking bench for demux8_4bits_seq: directed vector table, hand-written
// multi-cycle corner cases and randomized traffic against a frame-level model.
module tb_demux8_4bits_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] D;
  logic       valid;
  logic       auto_mode;
  logic [2:0] sel;
  logic [3:0] y [8];
  logic [7:0] filled;
  logic [2:0] ptr;
  logic       frame_done;
`ifdef DEMUX8_PARITY_EN
  logic [7:0] par;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  demux8_4bits_seq dut (
    .clk        (clk),
    .rst        (rst),
    .D          (D),
    .valid      (valid),
    .auto_mode  (auto_mode),
    .sel        (sel),
    .Y0         (y[0]),
    .Y1         (y[1]),
    .Y2         (y[2]),
    .Y3         (y[3]),
    .Y4         (y[4]),
    .Y5         (y[5]),
    .Y6         (y[6]),
    .Y7         (y[7]),
    .filled     (filled),
    .ptr        (ptr),
    .frame_done (frame_done)
`ifdef DEMUX8_PARITY_EN
    ,
    .par        (par)
`endif
  );

  // Frame-level model: a set of written slots, a pointer and a "frame just completed" flag.
  logic [3:0] m_y [8];
  bit         m_written [8];
  int         m_ptr;
  bit         m_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int written_count();
    int n = 0;
    for (int k = 0; k < 8; k++) n += m_written[k] ? 1 : 0;
    return n;
  endfunction

  function automatic logic [7:0] model_filled();
    logic [7:0] m = '0;
    for (int k = 0; k < 8; k++) m[k] = m_written[k];
    return m;
  endfunction

  task automatic model_step(input logic r, input logic v, input logic am,
                            input logic [2:0] s, input logic [3:0] d);
    int t;
    if (r) begin
      for (int k = 0; k < 8; k++) begin
        m_y[k] = 4'h0;
        m_written[k] = 0;
      end
      m_ptr  = 0;
      m_done = 0;
    end else if (v) begin
      t = am ? m_ptr : int'(s);
      if (m_done) begin
        for (int k = 0; k < 8; k++) m_written[k] = 0;
      end
      m_y[t]       = d;
      m_written[t] = 1;
      if (am) m_ptr = (m_ptr + 1) % 8;
      m_done = (written_count() == 8);
    end else if (m_done) begin
      for (int k = 0; k < 8; k++) m_written[k] = 0;
      m_done = 0;
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 8; k++) begin
      check($sformatf("y%0d", k), 32'(y[k]), 32'(m_y[k]));
`ifdef DEMUX8_PARITY_EN
      check($sformatf("par%0d", k), 32'(par[k]), 32'(^m_y[k]));
`endif
    end
    check("filled", 32'(filled), 32'(model_filled()));
    check("ptr", 32'(ptr), 32'(m_ptr));
    check("frame_done", 32'(frame_done), 32'(m_done));
  endtask

  // Drive inputs, take one rising edge, advance the model, sample 1 time unit later.
  task automatic cycle(input logic r, input logic v, input logic am,
                       input logic [2:0] s, input logic [3:0] d);
    rst = r; valid = v; auto_mode = am; sel = s; D = d;
    @(posedge clk);
    model_step(r, v, am, s, d);
    #1;
    check_all();
  endtask

  typedef struct {
    logic       r, v, am;
    logic [2:0] s;
    logic [3:0] d;
    logic [7:0] ef;
    logic [2:0] ep;
    logic       efd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic v, logic am, logic [2:0] s, logic [3:0] d,
                              logic [7:0] ef, logic [2:0] ep, logic efd);
    vec_t x;
    x.r = r; x.v = v; x.am = am; x.s = s; x.d = d;
    x.ef = ef; x.ep = ep; x.efd = efd;
    return x;
  endfunction

  initial begin
    logic [3:0] auto_data [8];
    int         fd_count;
    bit         prev_fd;

    auto_data = '{4'h6, 4'hB, 4'h2, 4'h7, 4'h8, 4'hF, 4'hC, 4'hA};
    rst = 1'b1; valid = 1'b0; auto_mode = 1'b0; sel = '0; D = '0;

    // Reset, auto fill, idle, addressed out-of-order fill with a duplicate, idle.
    tbl.push_back(mk(1, 0, 0, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 4'h6, 8'h01, 1, 0));
    tbl.push_back(mk(0, 1, 1, 0, 4'hB, 8'h03, 2, 0));
    tbl.push_back(mk(0, 1, 1, 0, 4'h2, 8'h07, 3, 0));
    tbl.push_back(mk(0, 1, 1, 0, 4'h7, 8'h0F, 4, 0));
    tbl.push_back(mk(0, 1, 1, 0, 4'h8, 8'h1F, 5, 0));
    tbl.push_back(mk(0, 1, 1, 0, 4'hF, 8'h3F, 6, 0));
    tbl.push_back(mk(0, 1, 1, 0, 4'hC, 8'h7F, 7, 0));
    tbl.push_back(mk(0, 1, 1, 0, 4'hA, 8'hFF, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 4'h0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 1, 0, 7, 4'h8, 8'h80, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 4'h1, 8'h81, 0, 0));
    tbl.push_back(mk(0, 1, 0, 3, 4'h4, 8'h89, 0, 0));
    tbl.push_back(mk(0, 1, 0, 3, 4'h4, 8'h89, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 4'h2, 8'h8B, 0, 0));
    tbl.push_back(mk(0, 1, 0, 2, 4'h3, 8'h8F, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4, 4'h5, 8'h9F, 0, 0));
    tbl.push_back(mk(0, 1, 0, 5, 4'h6, 8'hBF, 0, 0));
    tbl.push_back(mk(0, 1, 0, 6, 4'h7, 8'hFF, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 4'h0, 8'h00, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].r, tbl[i].v, tbl[i].am, tbl[i].s, tbl[i].d);
      check($sformatf("tbl%0d_filled", i), 32'(filled), 32'(tbl[i].ef));
      check($sformatf("tbl%0d_ptr", i), 32'(ptr), 32'(tbl[i].ep));
      check($sformatf("tbl%0d_fd", i), 32'(frame_done), 32'(tbl[i].efd));
      if (i == 9) begin
        for (int k = 0; k < 8; k++)
          check($sformatf("auto_y%0d", k), 32'(y[k]), 32'(auto_data[k]));
      end
    end
    check("addr_y3", 32'(y[3]), 32'h4);

    // Gapped auto fill, then a write in the DONE cycle opens the next frame.
    cycle(1, 0, 1, 0, 0);
    fd_count = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(0, 1, 1, 0, 4'(i + 1));
      fd_count += frame_done ? 1 : 0;
      if (i < 7) begin
        cycle(0, 0, 1, 0, 4'hF);
        fd_count += frame_done ? 1 : 0;
      end
    end
    check("gap_fd_count", 32'(fd_count), 32'd1);
    check("gap_in_done", 32'(frame_done), 32'd1);
    cycle(0, 1, 1, 0, 4'h9);
    check("b2b_onehot", 32'(filled), 32'h01);
    check("b2b_fd_drop", 32'(frame_done), 32'd0);
    for (int i = 0; i < 7; i++) begin
      cycle(0, 1, 1, 0, 4'(i + 3));
      check($sformatf("b2b_fd%0d", i), 32'(frame_done), (i == 6) ? 32'd1 : 32'd0);
    end

    // Reset mid-frame takes priority over a concurrent write.
    for (int i = 0; i < 4; i++) cycle(0, 1, 1, 0, 4'(i + 5));
    cycle(1, 1, 1, 0, 4'hE);
    check("midrst_filled", 32'(filled), 32'h00);
    check("midrst_ptr", 32'(ptr), 32'd0);
    check("midrst_fd", 32'(frame_done), 32'd0);
    for (int k = 0; k < 8; k++)
      check($sformatf("midrst_y%0d", k), 32'(y[k]), 32'h0);

`ifdef DEMUX8_PARITY_EN
    cycle(0, 1, 0, 2, 4'hB);
    check("par2_b", 32'(par[2]), 32'd1);
    cycle(0, 1, 0, 2, 4'h6);
    check("par2_6", 32'(par[2]), 32'd0);
`endif

    // Random traffic with mode switches, gaps and occasional resets.
    prev_fd = 1'b0;
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 79) == 0), ($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
      check("fd_not_consecutive", 32'(prev_fd & frame_done), 32'd0);
      prev_fd = frame_done;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
